// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: datapath widths, bubble instruction, opcodes and
// the fetch-stage state type used by all stages and the hazard logic.
package mips_pkg;

  localparam int unsigned PC_W   = 10;
  localparam int unsigned INST_W = 32;

  // sll $0,$0,0
  localparam logic [31:0] NOP = 32'h0000_0000;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;

  typedef enum logic [5:0] {
    OpR    = 6'b000000,
    OpJ    = 6'b000010,
    OpBeq  = 6'b000100,
    OpAddi = 6'b001000,
    OpLw   = 6'b100011,
    OpSw   = 6'b101011
  } opcode_e;

  // StPrime: memory output is stale; StRun: a fetched word is in flight.
  typedef enum logic {
    StPrime = 1'b0,
    StRun   = 1'b1
  } fetch_state_e;

  function automatic logic [5:0] opcode_of(input logic [31:0] inst);
    return inst[31:26];
  endfunction

endpackage

// File: rtl/estagio_busca.sv
// Instruction-fetch stage: owns the PC, drives the synchronous instruction memory and
// realigns its one-cycle latency into {IR, PC, valid} for decode.
module estagio_busca
  import mips_pkg::*;
#(
  parameter int unsigned         PC_W     = mips_pkg::PC_W,
  parameter int unsigned         INST_W   = mips_pkg::INST_W,
  parameter logic [PC_W-1:0]     RESET_PC = '0,
  parameter logic [INST_W-1:0]   NOP      = INST_W'(mips_pkg::NOP)
) (
  input  logic              if_in_clk,
  input  logic              if_in_rst,
  input  logic              if_in_stall,
  input  logic              if_in_flush,
  input  logic              if_in_redirect,
  input  logic [PC_W-1:0]   if_in_target,
  output logic [PC_W-1:0]   if_out_mem_addr,
  input  logic [INST_W-1:0] if_in_mem_q,
  output logic [INST_W-1:0] if_out_ir,
  output logic [PC_W-1:0]   if_out_pc,
  output logic              if_out_valid,
  output logic [31:0]       if_out_count
);

  logic [PC_W-1:0]   r_pc;
  logic [PC_W-1:0]   r_f_pc;
  fetch_state_e      r_state;
  logic [INST_W-1:0] r_ir;
  logic [PC_W-1:0]   r_out_pc;
  logic              r_valid;
  logic [31:0]       r_count;

  logic [PC_W-1:0]   w_pc_d;
  logic [PC_W-1:0]   w_f_pc_d;
  fetch_state_e      w_state_d;
  logic [INST_W-1:0] w_ir_d;
  logic [PC_W-1:0]   w_out_pc_d;
  logic              w_valid_d;
  logic              w_deliver;
  logic [31:0]       w_count_d;

  // A stall replays the in-flight address so the memory keeps presenting the same word.
  assign if_out_mem_addr = if_in_redirect ? if_in_target :
                           if_in_stall    ? r_f_pc       : r_pc;

  always_comb begin
    w_pc_d     = r_pc;
    w_f_pc_d   = r_f_pc;
    w_state_d  = r_state;
    w_ir_d     = r_ir;
    w_out_pc_d = r_out_pc;
    w_valid_d  = r_valid;
    w_deliver  = 1'b0;

    if (if_in_redirect) begin
      w_ir_d    = NOP;
      w_valid_d = 1'b0;
      w_f_pc_d  = if_in_target;
      w_state_d = StRun;
      w_pc_d    = if_in_target + PC_W'(1);
    end else if (if_in_stall) begin
      if (if_in_flush) begin
        w_ir_d    = NOP;
        w_valid_d = 1'b0;
      end
    end else begin
      // A flush still advances fetch; only the word leaving memory is dropped.
      w_deliver  = (r_state == StRun) && !if_in_flush;
      w_valid_d  = w_deliver;
      w_ir_d     = w_deliver ? if_in_mem_q : NOP;
      w_out_pc_d = r_f_pc;
      w_f_pc_d   = r_pc;
      w_state_d  = StRun;
      w_pc_d     = r_pc + PC_W'(1);
    end

    w_count_d = r_count + 32'(w_deliver);
  end

  always_ff @(posedge if_in_clk or negedge if_in_rst) begin
    if (!if_in_rst) begin
      r_pc     <= RESET_PC;
      r_f_pc   <= RESET_PC;
      r_state  <= StPrime;
      r_ir     <= NOP;
      r_out_pc <= '0;
      r_valid  <= 1'b0;
      r_count  <= '0;
    end else begin
      r_pc     <= w_pc_d;
      r_f_pc   <= w_f_pc_d;
      r_state  <= w_state_d;
      r_ir     <= w_ir_d;
      r_out_pc <= w_out_pc_d;
      r_valid  <= w_valid_d;
      r_count  <= w_count_d;
    end
  end

  assign if_out_ir    = r_ir;
  assign if_out_pc    = r_out_pc;
  assign if_out_valid = r_valid;
  assign if_out_count = r_count;

endmodule

// File: tb/tb_estagio_busca.sv
// Bench for estagio_busca: 1-cycle synchronous memory model (mem[i] = A000_0000 + i) and a
// stream-level reference model of the delivered instruction sequence.
module tb_estagio_busca;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        flush;
  logic        redirect;
  logic [9:0]  target;
  logic [9:0]  mem_addr;
  logic [31:0] mem_q;
  logic [31:0] ir;
  logic [9:0]  opc;
  logic        valid;
  logic [31:0] count;

  int total = 0;
  int bad   = 0;

  // Reference model: next address the stream will deliver, and bubbles still owed before it.
  int unsigned m_seq;
  int unsigned m_gap;
  logic [31:0] m_ir;
  logic [9:0]  m_pc;
  logic        m_valid;
  logic [31:0] m_cnt;

  estagio_busca dut (
    .if_in_clk      (clk),
    .if_in_rst      (rst_n),
    .if_in_stall    (stall),
    .if_in_flush    (flush),
    .if_in_redirect (redirect),
    .if_in_target   (target),
    .if_out_mem_addr(mem_addr),
    .if_in_mem_q    (mem_q),
    .if_out_ir      (ir),
    .if_out_pc      (opc),
    .if_out_valid   (valid),
    .if_out_count   (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) mem_q <= 32'hA000_0000 + {22'b0, mem_addr};

  task automatic model_reset();
    m_seq = 0; m_gap = 1; m_ir = 32'h0; m_pc = 10'd0; m_valid = 1'b0; m_cnt = 0;
  endtask

  task automatic bubble();
    m_ir = 32'h0; m_valid = 1'b0;
  endtask

  task automatic step(input logic s, input logic f, input logic r, input logic [9:0] t);
    stall = s; flush = f; redirect = r; target = t;
    @(posedge clk);
    if (r) begin
      bubble(); m_seq = t; m_gap = 0;
    end else if (s) begin
      if (f) bubble();
    end else if (f || m_gap > 0) begin
      bubble();
      if (m_gap > 0) m_gap--;
      else m_seq = (m_seq + 1) % 1024;
    end else begin
      m_ir = 32'hA000_0000 + m_seq; m_pc = 10'(m_seq); m_valid = 1'b1;
      m_cnt++; m_seq = (m_seq + 1) % 1024;
    end
    #1;
    stall = 1'b0; flush = 1'b0; redirect = 1'b0;
  endtask

  task automatic apply_reset();
    stall = 1'b0; flush = 1'b0; redirect = 1'b0; target = '0;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; redirect = 1'b0; target = '0;
    #12;
    total++;
    if ({ir, opc, valid, count} !== {32'h0, 10'd0, 1'b0, 32'd0}) begin
      bad++;
      $display("FAIL reset_state ir=%h pc=%0d valid=%b count=%0d required 0/0/0/0",
               ir, opc, valid, count);
    end
    total++;
    if (mem_addr !== 10'd0) begin
      bad++; $display("FAIL reset_mem_addr got %0d required 0", mem_addr);
    end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_ir;
    apply_reset();
    for (int k = 1; k <= 6; k++) begin
      step(1'b0, 1'b0, 1'b0, '0);
      exp_ir = (k == 1) ? 32'h0 : 32'hA000_0000 + 32'(k - 2);
      total++;
      if (ir !== exp_ir || valid !== (k != 1)) begin
        bad++;
        $display("FAIL seq_edge%0d ir=%h valid=%b required %h/%b", k, ir, valid, exp_ir, k != 1);
      end
      if (k > 1) begin
        total++;
        if (opc !== 10'(k - 2)) begin
          bad++; $display("FAIL seq_pc%0d got %0d required %0d", k, opc, k - 2);
        end
      end
    end
    total++;
    if (count !== m_cnt || m_cnt != 5) begin
      bad++; $display("FAIL seq_count got %0d required %0d", count, m_cnt);
    end
  endtask

  task automatic test_stall();
    apply_reset();
    for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 1'b0, '0);
    stall = 1'b1;
    #1;
    total++;
    if (mem_addr !== 10'd3) begin
      bad++; $display("FAIL stall_mem_addr got %0d required 3", mem_addr);
    end
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b0, 1'b0, '0);
      total++;
      if (ir !== 32'hA000_0002 || opc !== 10'd2 || valid !== 1'b1) begin
        bad++;
        $display("FAIL stall_hold%0d ir=%h pc=%0d valid=%b required A0000002/2/1",
                 k, ir, opc, valid);
      end
    end
    step(1'b0, 1'b0, 1'b0, '0);
    total++;
    if (ir !== 32'hA000_0003 || opc !== 10'd3) begin
      bad++; $display("FAIL stall_release ir=%h pc=%0d required A0000003/3", ir, opc);
    end
  endtask

  task automatic test_redirect();
    apply_reset();
    for (int k = 0; k < 6; k++) step(1'b0, 1'b0, 1'b0, '0);
    redirect = 1'b1; target = 10'd10;
    #1;
    total++;
    if (mem_addr !== 10'd10) begin
      bad++; $display("FAIL redir_mem_addr got %0d required 10", mem_addr);
    end
    step(1'b0, 1'b0, 1'b1, 10'd10);
    total++;
    if (ir !== 32'h0 || valid !== 1'b0) begin
      bad++; $display("FAIL redir_bubble ir=%h valid=%b required 0/0", ir, valid);
    end
    step(1'b0, 1'b0, 1'b0, '0);
    total++;
    if (ir !== 32'hA000_000A || opc !== 10'd10 || valid !== 1'b1) begin
      bad++; $display("FAIL redir_target ir=%h pc=%0d required A000000A/10", ir, opc);
    end
    step(1'b0, 1'b0, 1'b0, '0);
    total++;
    if (ir !== 32'hA000_000B || opc !== 10'd11) begin
      bad++; $display("FAIL redir_next ir=%h pc=%0d required A000000B/11", ir, opc);
    end
  endtask

  task automatic test_priority();
    step(1'b1, 1'b0, 1'b1, 10'd20);
    total++;
    if (ir !== 32'h0 || valid !== 1'b0) begin
      bad++; $display("FAIL prio_redir_stall ir=%h valid=%b required 0/0", ir, valid);
    end
    step(1'b0, 1'b0, 1'b0, '0);
    total++;
    if (ir !== 32'hA000_0014 || opc !== 10'd20) begin
      bad++; $display("FAIL prio_redir_target ir=%h pc=%0d required A0000014/20", ir, opc);
    end
    step(1'b1, 1'b1, 1'b0, '0);
    total++;
    if (ir !== 32'h0 || valid !== 1'b0) begin
      bad++; $display("FAIL prio_stall_flush ir=%h valid=%b required 0/0", ir, valid);
    end
    step(1'b0, 1'b0, 1'b0, '0);
    total++;
    if (ir !== 32'hA000_0015 || opc !== 10'd21) begin
      bad++; $display("FAIL prio_pc_held ir=%h pc=%0d required A0000015/21", ir, opc);
    end
    step(1'b0, 1'b1, 1'b0, '0);
    step(1'b0, 1'b0, 1'b0, '0);
    total++;
    if (ir !== 32'hA000_0017 || opc !== 10'd23) begin
      bad++; $display("FAIL flush_discard ir=%h pc=%0d required A0000017/23", ir, opc);
    end
  endtask

  task automatic test_wrap();
    step(1'b0, 1'b0, 1'b1, 10'd1023);
    step(1'b0, 1'b0, 1'b0, '0);
    total++;
    if (ir !== 32'hA000_03FF || opc !== 10'd1023) begin
      bad++; $display("FAIL wrap_last ir=%h pc=%0d required A00003FF/1023", ir, opc);
    end
    step(1'b0, 1'b0, 1'b0, '0);
    total++;
    if (ir !== 32'hA000_0000 || opc !== 10'd0) begin
      bad++; $display("FAIL wrap_zero ir=%h pc=%0d required A0000000/0", ir, opc);
    end
  endtask

  task automatic test_random();
    logic s, f, r;
    apply_reset();
    for (int k = 0; k < 400; k++) begin
      r = ($urandom_range(99, 0) < 10);
      s = ($urandom_range(99, 0) < 25);
      f = ($urandom_range(99, 0) < 15);
      step(s, f, r, 10'($urandom_range(1023, 0)));
      total++;
      if (ir !== m_ir || valid !== m_valid || count !== m_cnt ||
          (m_valid && opc !== m_pc)) begin
        bad++;
        $display("FAIL rand_cyc%0d ir=%h valid=%b pc=%0d count=%0d required %h/%b/%0d/%0d",
                 k, ir, valid, opc, count, m_ir, m_valid, m_pc, m_cnt);
      end
    end
  endtask

  task automatic test_async_reset();
    for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 1'b0, '0);
    #3;
    rst_n = 1'b0;
    #1;
    total++;
    if ({ir, opc, valid, count} !== {32'h0, 10'd0, 1'b0, 32'd0}) begin
      bad++;
      $display("FAIL async_reset ir=%h pc=%0d valid=%b count=%0d required 0/0/0/0",
               ir, opc, valid, count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    step(1'b0, 1'b0, 1'b0, '0);
    step(1'b0, 1'b0, 1'b0, '0);
    total++;
    if (ir !== 32'hA000_0000 || opc !== 10'd0 || valid !== 1'b1 || count !== 32'd1) begin
      bad++;
      $display("FAIL async_restart ir=%h pc=%0d valid=%b count=%0d required A0000000/0/1/1",
               ir, opc, valid, count);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_priority();
    test_wrap();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
